// File: rtl/mont_mul_r2.sv
// mont_mul_r2 -- radix-2 bit-serial Montgomery multiplier.
//
// Computes result = x * y * 2^-WIDTH mod n. It processes one bit of x per clock,
// so an odd-modulus operation takes WIDTH CALC cycles plus one SUB cycle.
//
// Optional feature macro: MONT_MUL_R2_FINAL_SUB_EN
//   defined   : SUB subtracts n once when the accumulator is >= n, giving result < n.
//   undefined : SUB passes the accumulator through unchanged. The result is then
//               only congruent mod n (result < 2n when x, y < n).
//
// Handshake: start is a request pulse. It is taken only in IDLE; any start seen
// in CALC, SUB or DONE is dropped. An accepted odd-n request raises busy from
// the next cycle until done. An even n skips the computation and pulses done
// with err=1. result and err hold their values from one done to the next.
//
// Ports:
//   clk       clock; all state changes on the rising edge
//   mm_rst_n  synchronous active-low reset
//   start     request pulse (sampled in IDLE only)
//   x, y, n   multiplicand, multiplier, modulus (WIDTH bits each)
//   busy      operation in flight (CALC/SUB)
//   done      one-cycle completion pulse
//   err       modulus was even (valid with done)
//   result    Montgomery product (WIDTH+1 bits)
//   dbg_state current FSM state (IDLE=0, CALC=1, SUB=2, DONE=3)
module mont_mul_r2 #(
  parameter int WIDTH = 2048
) (
  input  logic             clk,
  input  logic             mm_rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [WIDTH-1:0] n,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH:0]   result,
  output logic [1:0]       dbg_state
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    SUB  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] x_r;
  logic [WIDTH-1:0] y_r;
  logic [WIDTH-1:0] n_r;
  logic [WIDTH+1:0] acc;
  logic [CW-1:0]    cnt;

  logic [WIDTH+1:0] sum_xy;
  logic [WIDTH+1:0] sum_q;
  logic [WIDTH+1:0] acc_nxt;
  logic [WIDTH:0]   fin;

  assign dbg_state = state;

  // One Montgomery step. The accumulator stays below y + n, so WIDTH+2 bits
  // hold A + x[i]*y + q*n without truncation.
  always_comb begin
    sum_xy  = acc + (x_r[cnt] ? {2'b00, y_r} : '0);
    sum_q   = sum_xy + (sum_xy[0] ? {2'b00, n_r} : '0);
    acc_nxt = sum_q >> 1;
  end

  // Final correction applied in SUB.
  always_comb begin
`ifdef MONT_MUL_R2_FINAL_SUB_EN
    if (acc >= {2'b00, n_r}) fin = (WIDTH+1)'(acc - {2'b00, n_r});
    else                     fin = acc[WIDTH:0];
`else
    fin = acc[WIDTH:0];
`endif
  end

  always_ff @(posedge clk) begin
    if (!mm_rst_n) begin
      state  <= IDLE;
      x_r    <= '0;
      y_r    <= '0;
      n_r    <= '0;
      acc    <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
      result <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (n[0]) begin
              x_r   <= x;
              y_r   <= y;
              n_r   <= n;
              acc   <= '0;
              cnt   <= '0;
              busy  <= 1'b1;
              state <= CALC;
            end else begin
              // An even modulus has no inverse of 2, so report it at once.
              err    <= 1'b1;
              result <= '0;
              done   <= 1'b1;
              state  <= DONE;
            end
          end
        end
        CALC: begin
          acc <= acc_nxt;
          cnt <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) state <= SUB;
        end
        SUB: begin
          result <= fin;
          err    <= 1'b0;
          busy   <= 1'b0;
          done   <= 1'b1;
          state  <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
